// File: rtl/secded_pkg.sv
// Shared SECDED layout for the 32-bit data / 39-bit codeword encoder and decoder.
// Keeping the layout here gives both sides of the storage path a single source.
//   Codeword index i, 1-based position pos = i+1.
//   Hamming parity k sits at index 2^k - 1 (k = 0..5).
//   Overall parity sits at index CODE_W-1.
//   Data bits fill the remaining indices in ascending order.
package secded_pkg;

    localparam int DATA_W = 32;
    localparam int PAR_W  = 6;
    localparam int CODE_W = DATA_W + PAR_W + 1;

    function automatic logic is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Codeword index that carries data bit j.
    function automatic int data_idx(input int j);
        int n;
        int idx;
        n   = 0;
        idx = 0;
        for (int i = 0; i < CODE_W - 1; i++) begin
            if (!is_pow2(i + 1)) begin
                if (n == j) idx = i;
                n++;
            end
        end
        return idx;
    endfunction

    // Data indices covered by Hamming parity bit k.
    function automatic logic [CODE_W-1:0] cov_mask(input int k);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int i = 0; i < CODE_W - 1; i++) begin
            if ((((i + 1) >> k) & 1) == 1 && !is_pow2(i + 1)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/secded_encode_comb.sv
// Combinational SECDED encoder: scatters the data word into the codeword
// layout and fills in the six Hamming bits. With WITH_OVERALL=1 the overall
// parity bit is added too; otherwise that bit is left at 0.
// Ports:
//   data_i  [DATA_W-1:0]  data word
//   code_o  [CODE_W-1:0]  codeword
module secded_encode_comb
    import secded_pkg::*;
#(
    parameter bit WITH_OVERALL = 1'b0
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [CODE_W-1:0] code_o
);

    logic [CODE_W-1:0] scat;
    logic [PAR_W-1:0]  par;
    logic [CODE_W-1:0] code_nov;

    always_comb begin
        scat = '0;
        for (int j = 0; j < DATA_W; j++) begin
            scat[data_idx(j)] = data_i[j];
        end

        par = '0;
        for (int k = 0; k < PAR_W; k++) begin
            par[k] = ^(scat & cov_mask(k));
        end

        code_nov = scat;
        for (int k = 0; k < PAR_W; k++) begin
            code_nov[(1 << k) - 1] = par[k];
        end

        code_o = code_nov;
        if (WITH_OVERALL) begin
            code_o[CODE_W-1] = ^code_nov[CODE_W-2:0];
        end
    end

endmodule

// File: rtl/secded_encoder_pipe.sv
// Two-stage pipelined SECDED encoder with valid/ready on both sides,
// per-word error-injection mask and a delivered-word counter.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_data             data word to encode
//   in_inj_mask         XORed onto the finished codeword
//   out_valid/out_ready output handshake
//   out_code            codeword, driven straight from the S2 register
//   enc_count           delivered codewords, wraps modulo 2^32
module secded_encoder_pipe
    import secded_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CODE_W-1:0] in_inj_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [31:0]       enc_count
);

    if (DATA_W != 32) begin : g_bad_width
        $fatal(1, "secded_encoder_pipe: only DATA_W=32 is supported");
    end

    logic              s1_valid_q;
    logic [CODE_W-1:0] s1_code_q, s1_code_d;
    logic [CODE_W-1:0] s1_mask_q;
    logic              s2_valid_q;
    logic [CODE_W-1:0] s2_code_q, s2_code_d;
    logic [31:0]       enc_count_q;

    logic s1_adv, s2_adv;
    logic in_fire, out_fire;

    // S1 holds the codeword without overall parity (top bit is 0).
    secded_encode_comb #(
        .WITH_OVERALL(1'b0)
    ) u_enc (
        .data_i(in_data),
        .code_o(s1_code_d)
    );

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign in_fire  = in_valid && s1_adv;
    assign out_fire = s2_valid_q && out_ready;

    // Overall parity is taken over the clean codeword, before injection,
    // so a mask bit can corrupt the overall bit like any other.
    assign s2_code_d = (s1_code_q | {^s1_code_q[CODE_W-2:0], {(CODE_W-1){1'b0}}})
                       ^ s1_mask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_code_q   <= '0;
            s1_mask_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_code_q   <= '0;
            enc_count_q <= '0;
        end else begin
            if (s1_adv) s1_valid_q <= in_valid;
            if (in_fire) begin
                s1_code_q <= s1_code_d;
                s1_mask_q <= in_inj_mask;
            end
            if (s2_adv) s2_valid_q <= s1_valid_q;
            if (s1_valid_q && s2_adv) s2_code_q <= s2_code_d;
            if (out_fire) enc_count_q <= enc_count_q + 32'd1;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_code  = s2_code_q;
    assign enc_count = enc_count_q;

endmodule
